alu_exec_unit: RTL and testbench

Parametrised execute-stage ALU for the pipelined RISC core, merging ALU-control decode and the datapath into one handshaked stage. It decodes the 3-bit ALUOp from the main controller and the 6-bit R-type funct field, computes a registered result with zero/overflow/illegal flags, and adds an iterative multi-cycle multiply. It sits between the ID/EX register and the EX/MEM register, with valid/ready backpressure and a hazard-unit flush.

---
 rtl/alu_pkg.sv | 76 +++++++
 rtl/alu_mul_iter.sv | 63 ++++++
 rtl/alu_exec_unit.sv | 147 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU.
// Contents: ALUOp and funct encodings, the internal operation enum, the
// FSM state enum and the ALUOp/funct decoder function.
package alu_pkg;

  // ALUOp encodings from the main controller
  localparam logic [2:0] ALUOP_ADD   = 3'b000;
  localparam logic [2:0] ALUOP_SUB   = 3'b001;
  localparam logic [2:0] ALUOP_RTYPE = 3'b010;
  localparam logic [2:0] ALUOP_AND   = 3'b011;
  localparam logic [2:0] ALUOP_OR    = 3'b100;
  localparam logic [2:0] ALUOP_ILL   = 3'b101;
  localparam logic [2:0] ALUOP_XOR   = 3'b110;
  localparam logic [2:0] ALUOP_ADDU  = 3'b111;

  // R-type funct encodings
  localparam logic [5:0] FN_ADD  = 6'b100000;
  localparam logic [5:0] FN_ADDU = 6'b100001;
  localparam logic [5:0] FN_SUB  = 6'b100010;
  localparam logic [5:0] FN_SUBU = 6'b100011;
  localparam logic [5:0] FN_AND  = 6'b100100;
  localparam logic [5:0] FN_OR   = 6'b100101;
  localparam logic [5:0] FN_XOR  = 6'b100110;
  localparam logic [5:0] FN_SLT  = 6'b101010;
  localparam logic [5:0] FN_SLL  = 6'b000000;
  localparam logic [5:0] FN_SRL  = 6'b000010;
  localparam logic [5:0] FN_SRA  = 6'b000011;
  localparam logic [5:0] FN_MUL  = 6'b011000;

  typedef enum logic [3:0] {
    OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_AND, OP_OR, OP_XOR,
    OP_SLT, OP_SLL, OP_SRL, OP_SRA, OP_MUL, OP_ILL
  } alu_op_e;

  typedef enum logic {
    ST_IDLE,
    ST_MUL
  } alu_state_e;

  // Map ALUOp/funct to an internal operation; anything undecodable is OP_ILL.
  function automatic alu_op_e decode_op(input logic [2:0] aluop,
                                        input logic [5:0] fn,
                                        input logic       mul_en);
    alu_op_e op;
    op = OP_ILL;
    case (aluop)
      ALUOP_ADD:  op = OP_ADD;
      ALUOP_SUB:  op = OP_SUB;
      ALUOP_AND:  op = OP_AND;
      ALUOP_OR:   op = OP_OR;
      ALUOP_XOR:  op = OP_XOR;
      ALUOP_ADDU: op = OP_ADDU;
      ALUOP_ILL:  op = OP_ILL;
      ALUOP_RTYPE: begin
        case (fn)
          FN_ADD:  op = OP_ADD;
          FN_ADDU: op = OP_ADDU;
          FN_SUB:  op = OP_SUB;
          FN_SUBU: op = OP_SUBU;
          FN_AND:  op = OP_AND;
          FN_OR:   op = OP_OR;
          FN_XOR:  op = OP_XOR;
          FN_SLT:  op = OP_SLT;
          FN_SLL:  op = OP_SLL;
          FN_SRL:  op = OP_SRL;
          FN_SRA:  op = OP_SRA;
          FN_MUL:  op = mul_en ? OP_MUL : OP_ILL;
          default: op = OP_ILL;
        endcase
      end
      default: op = OP_ILL;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier producing the low XLEN bits of a*b.
// One partial product is accumulated per cycle while run is high; done
// and product_lo are valid in the cycle of the final (XLEN-th) iteration.
// Ports:
//   clk, rst_n        clock, async active-low reset
//   start             load operands and clear the iteration count
//   run               iterate this cycle (owner's FSM is in its MUL state)
//   abort             drop the operation in progress
//   mcand_in/mplier_in operands captured on start
//   done              final iteration this cycle (combinational)
//   product_lo        product low half, valid with done (combinational)
module alu_mul_iter
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            run,
  input  logic            abort,
  input  logic [XLEN-1:0] mcand_in,
  input  logic [XLEN-1:0] mplier_in,
  output logic            done,
  output logic [XLEN-1:0] product_lo
);

  localparam int unsigned CNT_W = $clog2(XLEN);

  logic [XLEN-1:0]  mcand;
  logic [XLEN-1:0]  mplier;
  logic [XLEN-1:0]  acc;
  logic [CNT_W-1:0] count;
  logic [XLEN-1:0]  acc_nxt;

  // Accumulator after this cycle's partial product
  assign acc_nxt    = acc + (mplier[0] ? mcand : '0);
  assign done       = run && (count == CNT_W'(XLEN - 1));
  assign product_lo = acc_nxt;

  // Operand shift registers, accumulator and iteration count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      count  <= '0;
    end else if (abort) begin
      count <= '0;
    end else if (start) begin
      mcand  <= mcand_in;
      mplier <= mplier_in;
      acc    <= '0;
      count  <= '0;
    end else if (run) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      count  <= done ? '0 : count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: ALUOp/funct decode, single-cycle datapath and an
// iterative multiply behind a valid/ready handshake with hazard flush.
// Ports:
//   clk, rst_n            clock, async active-low reset
//   flush                 synchronous pipeline flush (highest priority)
//   in_valid / in_ready   upstream handshake (in_ready is combinational)
//   alu_op, funct         ALUOp and R-type funct field
//   op_a, op_b, shamt     operands and shift amount
//   out_valid / out_ready downstream handshake
//   result, zero,         registered result and flags, held while
//   overflow, illegal     out_valid && !out_ready
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned SHAMT_W = $clog2(XLEN),
  parameter bit          MUL_EN  = 1'b1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [2:0]         alu_op,
  input  logic [5:0]         funct,
  input  logic [XLEN-1:0]    op_a,
  input  logic [XLEN-1:0]    op_b,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [XLEN-1:0]    result,
  output logic               zero,
  output logic               overflow,
  output logic               illegal
);

  alu_state_e      state;
  alu_state_e      state_nxt;
  alu_op_e         dec_op;
  logic            accept;
  logic            load_sc;
  logic            mul_start;
  logic            mul_done;
  logic [XLEN-1:0] mul_prod;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic            add_ovf;
  logic            sub_ovf;
  logic [XLEN-1:0] sc_result;
  logic            sc_overflow;

  assign dec_op   = decode_op(alu_op, funct, MUL_EN);
  assign in_ready = (state == ST_IDLE) && (!out_valid || out_ready) && !flush;
  assign accept   = in_valid && in_ready;
  assign load_sc  = accept && (dec_op != OP_MUL);
  assign mul_start = accept && (dec_op == OP_MUL);

  // Two's-complement overflow: operands agree in sign (add) or differ (sub)
  // and the result sign differs from op_a.
  assign sum     = op_a + op_b;
  assign diff    = op_a - op_b;
  assign add_ovf = (op_a[XLEN-1] == op_b[XLEN-1]) && (sum[XLEN-1]  != op_a[XLEN-1]);
  assign sub_ovf = (op_a[XLEN-1] != op_b[XLEN-1]) && (diff[XLEN-1] != op_a[XLEN-1]);

  // Single-cycle datapath; MUL and illegal ops produce zero here
  always_comb begin
    sc_result   = '0;
    sc_overflow = 1'b0;
    case (dec_op)
      OP_ADD:  begin sc_result = sum;  sc_overflow = add_ovf; end
      OP_SUB:  begin sc_result = diff; sc_overflow = sub_ovf; end
      OP_ADDU: sc_result = sum;
      OP_SUBU: sc_result = diff;
      OP_AND:  sc_result = op_a & op_b;
      OP_OR:   sc_result = op_a | op_b;
      OP_XOR:  sc_result = op_a ^ op_b;
      OP_SLT:  sc_result = XLEN'($signed(op_a) < $signed(op_b));
      OP_SLL:  sc_result = op_a << shamt;
      OP_SRL:  sc_result = op_a >> shamt;
      OP_SRA:  sc_result = XLEN'($signed(op_a) >>> shamt);
      default: sc_result = '0;
    endcase
  end

  alu_mul_iter #(
    .XLEN (XLEN)
  ) u_mul (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (mul_start),
    .run        (state == ST_MUL),
    .abort      (flush),
    .mcand_in   (op_a),
    .mplier_in  (op_b),
    .done       (mul_done),
    .product_lo (mul_prod)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state: flush always returns to IDLE
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (mul_start) state_nxt = ST_MUL;
        ST_MUL:  if (mul_done)  state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // Output register: flush > new load > handshake drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (load_sc) begin
      out_valid <= 1'b1;
      result    <= sc_result;
      zero      <= (sc_result == '0);
      overflow  <= sc_overflow;
      illegal   <= (dec_op == OP_ILL);
    end else if (mul_done) begin
      out_valid <= 1'b1;
      result    <= mul_prod;
      zero      <= (mul_prod == '0);
      overflow  <= 1'b0;
      illegal   <= 1'b0;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit: directed cases plus randomized
// traffic checked cycle by cycle against a behavioural reference model.
module tb_alu_exec_unit;

  localparam int unsigned XLEN    = 32;
  localparam int unsigned SHAMT_W = 5;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               flush;
  logic               in_valid;
  logic               in_ready;
  logic [2:0]         alu_op;
  logic [5:0]         funct;
  logic [XLEN-1:0]    op_a;
  logic [XLEN-1:0]    op_b;
  logic [SHAMT_W-1:0] shamt;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    result;
  logic               zero;
  logic               overflow;
  logic               illegal;

  alu_exec_unit #(.XLEN(XLEN), .SHAMT_W(SHAMT_W), .MUL_EN(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct     (funct),
    .op_a      (op_a),
    .op_b      (op_b),
    .shamt     (shamt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .overflow  (overflow),
    .illegal   (illegal)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic        m_valid;
  logic [31:0] m_res;
  logic        m_ovf;
  logic        m_ill;
  int          mul_left;
  logic [31:0] pend_res;

  localparam longint SMAX = 64'sd2147483647;
  localparam longint SMIN = -64'sd2147483648;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural ALU: plain arithmetic on wide signed values
  task automatic ref_alu(input logic [2:0] op, input logic [5:0] fn,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] sh,
                         output logic [31:0] r, output logic o,
                         output logic il, output logic m);
    longint sa, sb, s;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r = '0; o = 1'b0; il = 1'b0; m = 1'b0;
    case (op)
      3'd0: begin s = sa + sb; r = a + b; o = (s > SMAX) || (s < SMIN); end
      3'd1: begin s = sa - sb; r = a - b; o = (s > SMAX) || (s < SMIN); end
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd6: r = a ^ b;
      3'd7: r = a + b;
      3'd2: begin
        case (fn)
          6'h20: begin s = sa + sb; r = a + b; o = (s > SMAX) || (s < SMIN); end
          6'h21: r = a + b;
          6'h22: begin s = sa - sb; r = a - b; o = (s > SMAX) || (s < SMIN); end
          6'h23: r = a - b;
          6'h24: r = a & b;
          6'h25: r = a | b;
          6'h26: r = a ^ b;
          6'h2a: r = (sa < sb) ? 32'd1 : 32'd0;
          6'h00: r = a << sh;
          6'h02: r = a >> sh;
          6'h03: r = 32'(sa >>> sh);
          6'h18: begin m = 1'b1; r = 32'(longint'(a) * longint'(b)); end
          default: il = 1'b1;
        endcase
      end
      default: il = 1'b1;
    endcase
  endtask

  task automatic set_exp(input logic [31:0] r, input logic o, input logic il);
    m_valid = 1'b1; m_res = r; m_ovf = o; m_ill = il;
  endtask

  task automatic model_reset();
    m_valid = 1'b0; m_res = '0; m_ovf = 1'b0; m_ill = 1'b0; mul_left = 0; pend_res = '0;
  endtask

  // One clock cycle: drive at negedge, predict, check outputs at next negedge
  task automatic step(input logic v, input logic [2:0] op, input logic [5:0] fn,
                      input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                      input logic ordy, input logic fl);
    logic exp_rdy;
    logic [31:0] r;
    logic o, il, m;
    in_valid = v; alu_op = op; funct = fn; op_a = a; op_b = b; shamt = sh;
    out_ready = ordy; flush = fl;
    #1;
    exp_rdy = (mul_left == 0) && (!m_valid || ordy) && !fl;
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    ref_alu(op, fn, a, b, sh, r, o, il, m);
    if (fl) begin
      m_valid = 1'b0;
      mul_left = 0;
    end else begin
      if (m_valid && ordy) m_valid = 1'b0;
      if (mul_left > 0) begin
        mul_left--;
        if (mul_left == 0) set_exp(pend_res, 1'b0, 1'b0);
      end else if (v && exp_rdy) begin
        if (m) begin
          mul_left = XLEN;
          pend_res = r;
        end else begin
          set_exp(r, o, il);
        end
      end
    end
    @(posedge clk);
    @(negedge clk);
    check("out_valid", 32'(out_valid), 32'(m_valid));
    if (m_valid) begin
      check("result",   result,         m_res);
      check("zero",     32'(zero),      32'(m_res == 32'd0));
      check("overflow", 32'(overflow),  32'(m_ovf));
      check("illegal",  32'(illegal),   32'(m_ill));
    end
  endtask

  task automatic idle();
    step(1'b0, 3'd0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b0);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom();
    endcase
  endfunction

  logic [5:0] fn_tab [0:12];
  int cyc;

  initial begin
    fn_tab[0] = 6'h20; fn_tab[1] = 6'h21; fn_tab[2]  = 6'h22; fn_tab[3]  = 6'h23;
    fn_tab[4] = 6'h24; fn_tab[5] = 6'h25; fn_tab[6]  = 6'h26; fn_tab[7]  = 6'h2a;
    fn_tab[8] = 6'h00; fn_tab[9] = 6'h02; fn_tab[10] = 6'h03; fn_tab[11] = 6'h18;
    fn_tab[12] = 6'h3f;

    model_reset();
    in_valid = 1'b0; alu_op = '0; funct = '0; op_a = '0; op_b = '0; shamt = '0;
    out_ready = 1'b1; flush = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_result",    result,         32'd0);
    check("rst_zero",      32'(zero),      32'd0);
    check("rst_overflow",  32'(overflow),  32'd0);
    check("rst_illegal",   32'(illegal),   32'd0);
    check("rst_in_ready",  32'(in_ready),  32'd1);
    rst_n = 1'b1;

    // Signed overflow on add; addu never overflows
    step(1'b1, 3'b010, 6'h20, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b0);
    check("add_ovf_result", result, 32'h8000_0000);
    check("add_ovf_flag", 32'(overflow), 32'd1);
    step(1'b1, 3'b010, 6'h21, 32'h7FFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b0);
    check("addu_ovf_flag", 32'(overflow), 32'd0);
    // Branch compare gives zero
    step(1'b1, 3'b001, 6'h00, 32'h1234, 32'h1234, 5'd0, 1'b1, 1'b0);
    check("sub_zero", 32'(zero), 32'd1);
    // Back-to-back single-cycle ops
    for (int i = 0; i < 6; i++)
      step(1'b1, 3'($urandom_range(0, 7)), fn_tab[$urandom_range(0, 10)],
           rand_operand(), rand_operand(), 5'($urandom()), 1'b1, 1'b0);
    // Shifts and slt
    step(1'b1, 3'b010, 6'h03, 32'h8000_0000, 32'hDEAD_BEEF, 5'd4, 1'b1, 1'b0);
    check("sra", result, 32'hF800_0000);
    step(1'b1, 3'b010, 6'h02, 32'h8000_0000, 32'hDEAD_BEEF, 5'd4, 1'b1, 1'b0);
    check("srl", result, 32'h0800_0000);
    step(1'b1, 3'b010, 6'h2a, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b1, 1'b0);
    check("slt", result, 32'd1);

    // Multiply latency
    step(1'b1, 3'b010, 6'h18, 32'd1234, 32'd5678, 5'd0, 1'b1, 1'b0);
    cyc = 0;
    for (int i = 0; i < 40; i++) begin
      idle();
      cyc++;
      if (out_valid) break;
    end
    check("mul_latency", 32'(cyc), 32'd32);
    check("mul_result", result, 32'd7006652);
    idle();

    // Backpressure hold
    step(1'b1, 3'b000, 6'h00, 32'd5, 32'd6, 5'd0, 1'b1, 1'b0);
    repeat (5) step(1'b1, 3'b011, 6'h00, 32'hFF, 32'h0F, 5'd0, 1'b0, 1'b0);
    check("bp_hold", result, 32'd11);
    idle();

    // Illegal encodings
    step(1'b1, 3'b101, 6'h20, 32'd7, 32'd9, 5'd0, 1'b1, 1'b0);
    check("ill_aluop", 32'(illegal), 32'd1);
    step(1'b1, 3'b010, 6'h3f, 32'd7, 32'd9, 5'd0, 1'b1, 1'b0);
    check("ill_funct_res", result, 32'd0);
    idle();

    // Flush mid-multiply
    step(1'b1, 3'b010, 6'h18, 32'hFFFF, 32'h1234, 5'd0, 1'b1, 1'b0);
    repeat (9) idle();
    step(1'b0, 3'd0, 6'd0, 32'd0, 32'd0, 5'd0, 1'b1, 1'b1);
    repeat (35) idle();
    step(1'b1, 3'b000, 6'h00, 32'd100, 32'd23, 5'd0, 1'b1, 1'b0);
    check("post_flush_add", result, 32'd123);
    idle();

    // Reset mid-multiply
    step(1'b1, 3'b010, 6'h18, 32'h1111, 32'h2222, 5'd0, 1'b1, 1'b0);
    repeat (9) idle();
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", 32'(out_valid), 32'd0);
    check("mid_rst_result",    result,         32'd0);
    check("mid_rst_in_ready",  32'(in_ready),  32'd1);
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (35) idle();
    step(1'b1, 3'b000, 6'h00, 32'd40, 32'd2, 5'd0, 1'b1, 1'b0);
    check("post_rst_add", result, 32'd42);
    idle();

    // Randomized traffic
    for (int i = 0; i < 700; i++) begin
      logic [5:0] fn;
      if ($urandom_range(0, 15) < 14) fn = fn_tab[$urandom_range(0, 12)];
      else                            fn = 6'($urandom());
      step(1'($urandom_range(0, 9) < 7), 3'($urandom_range(0, 7)), fn,
           rand_operand(), rand_operand(), 5'($urandom()),
           1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 39) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
